// File: rtl/ibex_hpm_ctrl_pkg.sv
// Shared constants for the performance-monitor control stage: CSR addresses and
// event-vector bit positions.
package ibex_hpm_ctrl_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;

    localparam int unsigned EV_CYCLE   = 0;
    localparam int unsigned EV_INSTRET = 1;

endpackage

// File: rtl/ibex_hpm_slot.sv
// One programmable mhpmcounter slot: holds its mhpmevent selector and raises an
// increment request when any selected event fired in the registered event vector.
module ibex_hpm_slot #(
    parameter int unsigned NumEvents = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [NumEvents-1:0] wdata_i,
    input  logic [NumEvents-1:0] ev_i,
    output logic [NumEvents-1:0] sel_o,
    output logic                 inc_o
);

    logic [NumEvents-1:0] sel_q, sel_d;

    always_comb begin
        sel_d = sel_q;
        if (we_i) begin
            sel_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Several selected events in one cycle still count only once.
    assign inc_o = |(ev_i & sel_q);
    assign sel_o = sel_q;

endmodule

// File: rtl/ibex_hpm_ctrl.sv
// Control stage in front of the machine counters: mcountinhibit, event selection,
// per-slot increment/load strobes and the counter CSR read mux.
module ibex_hpm_ctrl
    import ibex_hpm_ctrl_pkg::*;
#(
    parameter  int unsigned NumCounters = 10,
    parameter  int unsigned NumEvents   = 16,
    localparam int unsigned NC          = 3 + NumCounters
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumEvents-1:0] events_i,
    input  logic                 csr_we_i,
    input  logic [11:0]          csr_addr_i,
    input  logic [31:0]          csr_wdata_i,
    output logic [31:0]          csr_rdata_o,
    output logic                 csr_hit_o,
    input  logic [64*NC-1:0]     cnt_val_i,
    output logic [NC-1:0]        cnt_inc_o,
    output logic [NC-1:0]        cnt_we_o,
    output logic [NC-1:0]        cnt_weh_o,
    output logic [31:0]          cnt_wdata_o
);

    logic [NumEvents-1:0] ev_q;
    logic [NC-1:0]        inhibit_q, inhibit_d;
    logic [NC-1:0]        raw_inc;
    logic [NumEvents-1:0] evsel [NC];
    logic [4:0]           idx;
    logic                 sel_inhibit, sel_event, sel_cnt_lo, sel_cnt_hi;

    // Each CSR group is a 32-entry aligned window; low index bits pick the slot.
    assign idx         = csr_addr_i[4:0];
    assign sel_inhibit = (csr_addr_i == CSR_MCOUNTINHIBIT);
    assign sel_event   = (csr_addr_i[11:5] == CSR_MHPMEVENT3[11:5]) && (idx >= 5'd3);
    assign sel_cnt_lo  = (csr_addr_i[11:5] == CSR_MCYCLE[11:5]) && (idx != 5'd1);
    assign sel_cnt_hi  = (csr_addr_i[11:5] == CSR_MCYCLEH[11:5]) && (idx != 5'd1);
    assign csr_hit_o   = sel_inhibit | sel_event | sel_cnt_lo | sel_cnt_hi;

    always_comb begin
        inhibit_d = inhibit_q;
        if (csr_we_i && sel_inhibit) begin
            inhibit_d    = csr_wdata_i[NC-1:0];
            inhibit_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ev_q      <= '0;
            inhibit_q <= '0;
        end else begin
            ev_q      <= events_i;
            inhibit_q <= inhibit_d;
        end
    end

    assign raw_inc[0] = ev_q[EV_CYCLE];
    assign raw_inc[1] = 1'b0;
    assign raw_inc[2] = ev_q[EV_INSTRET];

    for (genvar j = 0; j < 3; j++) begin : g_fixed_sel
        assign evsel[j] = '0;
    end

    for (genvar k = 0; k < NumCounters; k++) begin : g_slot
        ibex_hpm_slot #(
            .NumEvents (NumEvents)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .we_i    (csr_we_i & sel_event & (idx == 5'(3 + k))),
            .wdata_i (csr_wdata_i[NumEvents-1:0]),
            .ev_i    (ev_q),
            .sel_o   (evsel[3 + k]),
            .inc_o   (raw_inc[3 + k])
        );
    end

    always_comb begin
        cnt_we_o  = '0;
        cnt_weh_o = '0;
        for (int i = 0; i < NC; i++) begin
            if (idx == 5'(i)) begin
                cnt_we_o[i]  = csr_we_i & sel_cnt_lo;
                cnt_weh_o[i] = csr_we_i & sel_cnt_hi;
            end
        end
    end

    // A software load wins over a same-cycle increment.
    assign cnt_inc_o   = raw_inc & ~inhibit_q & ~cnt_we_o & ~cnt_weh_o;
    assign cnt_wdata_o = csr_wdata_i;

    always_comb begin
        csr_rdata_o = '0;
        if (sel_inhibit) begin
            csr_rdata_o[NC-1:0] = inhibit_q;
        end
        for (int i = 0; i < NC; i++) begin
            if (idx == 5'(i)) begin
                if (sel_event) begin
                    csr_rdata_o[NumEvents-1:0] = evsel[i];
                end
                if (sel_cnt_lo) begin
                    csr_rdata_o = cnt_val_i[64*i +: 32];
                end
                if (sel_cnt_hi) begin
                    csr_rdata_o = cnt_val_i[64*i+32 +: 32];
                end
            end
        end
    end

endmodule
